// File: rtl/csub_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
`timescale 1ns/1ps
package csub_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned GROUP_W_DEF = 4;
    localparam int unsigned NGROUPS     = WIDTH_DEF / GROUP_W_DEF;
    localparam int unsigned GI_W        = $clog2(NGROUPS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/sub_slice.sv
// Combinational GROUP_W-bit carry-lookahead adder: s_g = a_g + nb_g + cin.
`timescale 1ns/1ps
module sub_slice #(
    parameter int unsigned GROUP_W = 4
) (
    input  logic [GROUP_W-1:0] a_g,
    input  logic [GROUP_W-1:0] nb_g,
    input  logic               cin,
    output logic [GROUP_W-1:0] s_g,
    output logic               cout
);

    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W:0]   w_c;

    assign w_p = a_g ^ nb_g;
    assign w_g = a_g & nb_g;

    // Each carry is a flat sum of products over generate/propagate terms.
    always_comb begin
        logic v_t;
        logic v_c;
        w_c = '0;
        v_t = 1'b0;
        v_c = 1'b0;
        for (int i = 0; i <= int'(GROUP_W); i++) begin
            v_t = cin;
            for (int j = 0; j < i; j++) begin
                v_t = v_t & w_p[j];
            end
            v_c = v_t;
            for (int k = 0; k < i; k++) begin
                v_t = w_g[k];
                for (int j = k + 1; j < i; j++) begin
                    v_t = v_t & w_p[j];
                end
                v_c = v_c | v_t;
            end
            w_c[i] = v_c;
        end
    end

    assign s_g  = w_p ^ w_c[GROUP_W-1:0];
    assign cout = w_c[GROUP_W];

endmodule

// File: rtl/csub32_serial.sv
// Digit-serial two's-complement subtractor computing a + ~b + 1, one group per clock.
// Optional zero/neg result flags are built when FLAGS_EN is defined.
`timescale 1ns/1ps
module csub32_serial
    import csub_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned GROUP_W = GROUP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
`ifdef FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int unsigned NG  = WIDTH / GROUP_W;
    localparam int unsigned GIW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [GIW-1:0] GI_LAST = GIW'(NG - 1);

    state_e             r_state;
    state_e             w_state_nx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_nb;
    logic [WIDTH-1:0]   r_diff;
    logic [WIDTH-1:0]   w_diff_nx;
    logic [GIW-1:0]     r_gi;
    logic               r_carry;
    logic               r_borrow;
    logic               r_overflow;
    logic [GROUP_W-1:0] w_a_g;
    logic [GROUP_W-1:0] w_nb_g;
    logic [GROUP_W-1:0] w_s_g;
    logic               w_cout;
    logic               w_last;
    logic               w_ovf;

    assign w_a_g  = r_a[r_gi*GROUP_W +: GROUP_W];
    assign w_nb_g = r_nb[r_gi*GROUP_W +: GROUP_W];
    assign w_last = (r_gi == GI_LAST);

    sub_slice #(
        .GROUP_W (GROUP_W)
    ) u_slice (
        .a_g  (w_a_g),
        .nb_g (w_nb_g),
        .cin  (r_carry),
        .s_g  (w_s_g),
        .cout (w_cout)
    );

    // Groups not yet computed keep their previous contents.
    always_comb begin
        w_diff_nx = r_diff;
        w_diff_nx[r_gi*GROUP_W +: GROUP_W] = w_s_g;
    end

    // r_nb holds ~b, so b's sign bit is its complement.
    assign w_ovf = (r_a[WIDTH-1] ^ ~r_nb[WIDTH-1]) & (r_a[WIDTH-1] ^ w_diff_nx[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            StIdle:  if (in_valid)  w_state_nx = StRun;
            StRun:   if (w_last)    w_state_nx = StDone;
            StDone:  if (out_ready) w_state_nx = StIdle;
            default: w_state_nx = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_nb       <= '0;
            r_diff     <= '0;
            r_gi       <= '0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_carry <= 1'b1;
                        r_gi    <= '0;
                    end
                end
                StRun: begin
                    r_diff  <= w_diff_nx;
                    r_carry <= w_cout;
                    r_gi    <= w_last ? '0 : r_gi + 1'b1;
                    if (w_last) begin
                        r_borrow   <= ~w_cout;
                        r_overflow <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (r_state == StRun && w_last) begin
            r_zero <= (w_diff_nx == '0);
            r_neg  <= w_diff_nx[WIDTH-1];
        end
    end

    assign zero = r_zero;
    assign neg  = r_neg;
`endif

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;

endmodule
